block_interleaver: RTL and testbench
====================================

# block_interleaver

Parametrised ROWS×COLS block interleaver/deinterleaver with ping-pong frame buffering and valid/ready handshakes on both sides. Each frame can be switched independently between interleave and deinterleave. It sits between the channel coder and the modulator on the TX path, or between the demodulator and the decoder on the RX path. It is the generalised successor of the fixed 4×4 deinterleaver: arbitrary geometry, symbol width, backpressure and two-frame buffering.

## Interface
- ROWS, 4, matrix rows (≥2)
- COLS, 4, matrix columns (≥2)
- DW, 1, symbol width in bits
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled with first symbol of each frame
- flush  in  1  synchronous abort: drop partial and stored frames
- in_valid  in  1  input symbol valid
- in_data  in  DW  input symbol
- in_ready  out  1  block can accept a symbol
- out_valid  out  1  output symbol valid
- out_data  out  DW  output symbol
- out_ready  in  1  downstream accepts symbol
- out_last  out  1  marks the final symbol of a frame (with out_valid)

## Operation
- N = ROWS*COLS symbols per frame. Two banks (0, 1) of N×DW flops. Each bank has a full flag and a latched mode bit.
- Write side: wr_bank, wr_idx 0..N-1. A symbol is accepted when in_valid && in_ready and is stored linearly at bank[wr_bank][wr_idx].
  - At wr_idx == 0, mode is latched into the bank's mode bit.
  - At wr_idx == N-1, the full flag is set, wr_idx wraps to 0 and wr_bank toggles.
- in_ready = !full[wr_bank].
- Read side: rd_bank, rd_idx 0..N-1. out_valid = full[rd_bank].
- Read address, with r = rd_idx:
  - Interleave (write row-major, read column-major): addr = (r % ROWS)*COLS + r / ROWS.
  - Deinterleave (inverse): addr = (r % COLS)*ROWS + r / COLS.
  - Implemented with row/col counters; no dividers.
- A symbol transfers when out_valid && out_ready. On the transfer at rd_idx == N-1: full[rd_bank] clears, rd_idx wraps and rd_bank toggles.
- out_last = out_valid && rd_idx == N-1.
- out_data = bank[rd_bank][addr] when out_valid, else 0.
- flush (synchronous, priority over everything but reset): clears both full flags, wr_idx, rd_idx, wr_bank and rd_bank. Storage contents are don't-care.
- Reset (rst low, asynchronous): same clearing as flush. Output reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0. Mid-frame reset discards all frames.

## Timing
- The write at wr_idx == N-1 sets full at that edge; out_valid is high the next cycle. Minimum latency from last input to first output is 1 cycle.
- The read at rd_idx == N-1 clears full at that edge; in_ready for that bank is high the next cycle.
- Sustained throughput is 1 symbol/cycle with out_ready held high. The write to bank B and the read from bank A run concurrently.
- Both banks full: in_ready = 0 until the read side finishes a frame.
- Simultaneous last write and last read in the same cycle: both take effect; no symbol lost.
- mode changes mid-frame are ignored until the next frame's first symbol.
- out_data and out_valid are stable while out_valid && !out_ready.

## Structure
- interleaver_pkg holds:
  - mode constants MODE_IL = 1'b0, MODE_DIL = 1'b1
  - a clog2-based index-width function
- Sub-module il_addr_gen (ROWS, COLS): row/col counters producing the permuted read address. Inputs: advance, clear, mode.

## Test plan
- ROWS=COLS=4, mode=1, inputs 0..15 → outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. out_last is high on 15.
- ROWS=2, COLS=3, mode=0, inputs 0..5 → outputs 0,3,1,4,2,5. Same geometry, mode=1, inputs 0,3,1,4,2,5 → 0..5 (round trip).
- 3 back-to-back frames, out_ready=1 → in_ready is never low and each frame's output starts 1 cycle after its last input.
- out_ready=0 held while 2 frames (32 symbols) are written → in_ready drops after symbol 32. After a single output transfer, in_ready stays low until 16 outputs are complete.
- Assert flush after 7 symbols of a frame → out_valid stays 0. The next 16 inputs form a clean frame.
- Drop rst mid-output → out_valid = 0, out_data = 0, in_ready = 1 immediately (asynchronous).

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared constants and helpers for the block interleaver.
// Mode encodings and the index-width function live here.
package interleaver_pkg;

  localparam logic MODE_IL  = 1'b0;
  localparam logic MODE_DIL = 1'b1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/il_addr_gen.sv
// Permuted read address generator for the block interleaver.
// Row/col counters replace the divide/modulo address formula.
module il_addr_gen
  import interleaver_pkg::*;
#(
  parameter int  ROWS = 4,
  parameter int  COLS = 4,
  localparam int N    = ROWS * COLS,
  localparam int IW   = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          advance_i,
  input  logic          clear_i,
  input  logic          mode_i,
  output logic [IW-1:0] addr_o
);

  logic [IW-1:0] minor_q, minor_d;
  logic [IW-1:0] major_q, major_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [IW-1:0] lim_m1;
  logic [IW-1:0] step;

  // minor walks the fast axis in strides of step; major is the base offset
  assign lim_m1 = (mode_i == MODE_DIL) ? IW'(COLS - 1) : IW'(ROWS - 1);
  assign step   = (mode_i == MODE_DIL) ? IW'(ROWS) : IW'(COLS);

  always_comb begin
    minor_d = minor_q;
    major_d = major_q;
    addr_d  = addr_q;
    if (clear_i) begin
      minor_d = '0;
      major_d = '0;
      addr_d  = '0;
    end else if (advance_i) begin
      if (minor_q == lim_m1) begin
        minor_d = '0;
        major_d = major_q + 1'b1;
        addr_d  = major_q + 1'b1;
      end else begin
        minor_d = minor_q + 1'b1;
        addr_d  = addr_q + step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      minor_q <= '0;
      major_q <= '0;
      addr_q  <= '0;
    end else begin
      minor_q <= minor_d;
      major_q <= major_d;
      addr_q  <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/block_interleaver.sv
// ROWS x COLS block interleaver/deinterleaver, ping-pong banks.
// Linear writes, permuted reads, per-frame mode latched on first symbol.
module block_interleaver
  import interleaver_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int N  = ROWS * COLS;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [DW-1:0] mem_q [2][N];
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] addr;
  logic          wr_fire, rd_fire;
  logic          wr_end, rd_end;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_end    = wr_idx_q == LAST;
  assign rd_end    = rd_idx_q == LAST;
  assign out_last  = out_valid && rd_end;
  assign out_data  = out_valid ? mem_q[rd_bank_q][addr] : '0;

  il_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr (
    .clk       (clk),
    .rst_ni    (rst),
    .advance_i (rd_fire && !rd_end),
    .clear_i   (flush || (rd_fire && rd_end)),
    .mode_i    (mode_q[rd_bank_q]),
    .addr_o    (addr)
  );

  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
    end else begin
      if (wr_fire) begin
        if (wr_idx_q == '0) mode_d[wr_bank_q] = mode;
        if (wr_end) begin
          full_d[wr_bank_q] = 1'b1;
          wr_idx_d          = '0;
          wr_bank_d         = !wr_bank_q;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
      // read bank is always full and write bank empty, so no clash here
      if (rd_fire) begin
        if (rd_end) begin
          full_d[rd_bank_q] = 1'b0;
          rd_idx_d          = '0;
          rd_bank_d         = !rd_bank_q;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_idx_q] <= in_data;
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Randomized bench for block_interleaver: 4x4 and 2x3 instances
// driven in lockstep and checked against a frame-queue model.
module tb_block_interleaver;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       ir [2];
  logic       ov [2];
  logic       ol [2];
  logic [7:0] od [2];

  int checks = 0;
  int failures = 0;

  int rr [2] = '{4, 2};
  int cc [2] = '{4, 3};
  int exp_q [2][$];
  int cur_q [2][$];
  logic cur_m [2];

  always #5 clk = ~clk;

  block_interleaver #(.ROWS(4), .COLS(4), .DW(8)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .out_last(ol[0])
  );

  block_interleaver #(.ROWS(2), .COLS(3), .DW(8)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .out_last(ol[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      cur_q[d].delete();
    end
  endtask

  // frame complete: emit symbols in the order the permutation defines
  task automatic model_emit(input int d);
    int n, a;
    n = rr[d] * cc[d];
    for (int r = 0; r < n; r++) begin
      if (cur_m[d] == 1'b0) a = (r % rr[d]) * cc[d] + r / rr[d];
      else                  a = (r % cc[d]) * rr[d] + r / cc[d];
      exp_q[d].push_back(cur_q[d][a]);
    end
    cur_q[d].delete();
  endtask

  task automatic cyc(input logic v, input logic [7:0] dat, input logic m,
                     input logic ordy, input logic fl);
    logic wf [2];
    logic rf [2];
    int   n, nq;
    logic e_ir, e_ov, e_ol;
    int   e_od;
    @(negedge clk);
    in_valid = v; in_data = dat; mode = m; out_ready = ordy; flush = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      n    = rr[d] * cc[d];
      nq   = exp_q[d].size();
      e_ir = ((nq + n - 1) / n) < 2;
      e_ov = nq > 0;
      e_od = (nq > 0) ? exp_q[d][0] : 0;
      e_ol = (nq > 0) && ((nq % n) == 1);
      chk($sformatf("in_ready%0d", d), int'(ir[d]), int'(e_ir));
      chk($sformatf("out_valid%0d", d), int'(ov[d]), int'(e_ov));
      chk($sformatf("out_data%0d", d), int'(od[d]), e_od);
      chk($sformatf("out_last%0d", d), int'(ol[d]), int'(e_ol));
      wf[d] = v && e_ir;
      rf[d] = ordy && e_ov;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      n = rr[d] * cc[d];
      if (fl) begin
        exp_q[d].delete();
        cur_q[d].delete();
      end else begin
        if (rf[d]) void'(exp_q[d].pop_front());
        if (wf[d]) begin
          if (cur_q[d].size() == 0) cur_m[d] = m;
          cur_q[d].push_back(int'(dat));
          if (cur_q[d].size() == n) model_emit(d);
        end
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && k < 200) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("drain_bound", int'(exp_q[0].size() + exp_q[1].size()), 0);
  endtask

  initial begin
    logic [7:0] rt [6];
    logic       fm;
    rt = '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5};
    rst = 1'b0; mode = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", int'(ir[d]), 1);
      chk("rst_out_valid", int'(ov[d]), 0);
      chk("rst_out_data", int'(od[d]), 0);
      chk("rst_out_last", int'(ol[d]), 0);
    end
    @(negedge clk);
    rst = 1'b1;

    // deinterleave 0..15 on the 4x4 instance
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    drain();

    // three back-to-back frames at full rate
    for (int f = 0; f < 3; f++) begin
      fm = 1'($urandom);
      for (int i = 0; i < 16; i++)
        cyc(1'b1, 8'($urandom), fm, 1'b1, 1'b0);
    end
    drain();

    // backpressure: two frames fill, third is stalled
    for (int i = 0; i < 34; i++)
      cyc(1'b1, 8'(100 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'd200, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'(201 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drain();

    // 2x3 round trip: interleave then deinterleave
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) cyc(1'b1, rt[i], 1'b1, 1'b1, 1'b0);
    drain();

    // flush a partial frame, then a clean frame
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(60 + i), 1'b1, 1'b1, 1'b0);
    drain();

    // random traffic with mode toggling and rare flushes
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, 8'($urandom), 1'($urandom),
          ($urandom % 3) != 0, ($urandom % 97) == 0);
    drain();

    // asynchronous reset while output is pending
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", int'(ov[0]), 1);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_in_ready", int'(ir[d]), 1);
      chk("async_out_valid", int'(ov[d]), 0);
      chk("async_out_data", int'(od[d]), 0);
      chk("async_out_last", int'(ol[d]), 0);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 7), 1'b0, 1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
